// File: rtl/cache_membus_bridge_pkg.sv
// Shared memory-interface types for the cache-to-membus bridge: access sizes,
// fault types, bridge FSM states and the alignment rule.
package cache_membus_bridge_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } MemSize;

  typedef enum logic {
    FE_NONE         = 1'b0,
    FE_ACCESS_FAULT = 1'b1
  } FaultTy;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE_RD = 3'd1,
    WAIT_RD  = 3'd2,
    ISSUE_WR = 3'd3,
    WAIT_WR  = 3'd4,
    RESP     = 3'd5
  } BridgeState;

  // Doublewords are never supported on a 32-bit bus, so they always fault.
  function automatic logic is_aligned(input MemSize size, input logic [1:0] offset);
    logic ok;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~offset[0];
      SIZE_W:  ok = (offset == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_byte_lane_merge.sv
// Combinational byte-lane helper: inserts store data into a bus word and
// extracts right-aligned, zero-extended load data from it.
module mem_byte_lane_merge
  import cache_membus_bridge_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] merged,
  output logic [31:0] load_data
);

  logic [4:0]  shamt;
  logic [31:0] lane_mask;

  assign shamt = {offset, 3'b000};

  always_comb begin
    case (MemSize'(size))
      SIZE_B:  lane_mask = 32'h0000_00FF;
      SIZE_H:  lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merged    = (old_word & ~(lane_mask << shamt)) | ((new_data & lane_mask) << shamt);
  assign load_data = (old_word >> shamt) & lane_mask;

endmodule

// File: rtl/cache_membus_bridge.sv
// Bridge from sized, byte-addressed cache requests to a word-wide memory bus,
// with read-modify-write for sub-word stores and alignment fault detection.
module cache_membus_bridge
  import cache_membus_bridge_pkg::*;
#(
  parameter bit CHECK_RESP_ADDR = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        creq_valid,
  output logic        creq_ready,
  input  logic [31:0] creq_addr,
  input  logic        creq_wen,
  input  logic [31:0] creq_wdata,
  input  logic [1:0]  creq_wmask,
  output logic        cresp_valid,
  output logic        cresp_error,
  output logic        cresp_errty,
  output logic [31:0] cresp_rdata,
  output logic        mreq_valid,
  input  logic        mreq_ready,
  output logic [31:0] mreq_addr,
  output logic        mreq_wen,
  output logic [31:0] mreq_wdata,
  input  logic        mresp_valid,
  input  logic        mresp_error,
  input  logic [31:0] mresp_addr,
  input  logic [31:0] mresp_rdata
);

  BridgeState  state_q, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  size_q;
  logic        wen_q, err_q;
  logic [31:0] word_addr, merged, load_data;
  logic        req_ok, resp_hit;

  assign word_addr = {addr_q[31:2], 2'b00};
  assign req_ok    = is_aligned(MemSize'(creq_wmask), creq_addr[1:0]);
  assign resp_hit  = mresp_valid && (!CHECK_RESP_ADDR || (mresp_addr == word_addr));

  mem_byte_lane_merge u_lane_merge (
    .old_word  (mresp_rdata),
    .new_data  (wdata_q),
    .size      (size_q),
    .offset    (addr_q[1:0]),
    .merged    (merged),
    .load_data (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath registers are never observed outside the states that load them,
  // so they carry no reset; every output below is gated by state.
  always_ff @(posedge clk) begin
    case (state_q)
      IDLE: if (creq_valid) begin
        addr_q  <= creq_addr;
        wen_q   <= creq_wen;
        wdata_q <= creq_wdata;
        size_q  <= creq_wmask;
        err_q   <= ~req_ok;
        rdata_q <= '0;
      end
      WAIT_RD: if (resp_hit) begin
        if (mresp_error) err_q   <= 1'b1;
        else if (!wen_q) rdata_q <= load_data;
        else             wdata_q <= merged;
      end
      WAIT_WR: if (resp_hit) err_q <= mresp_error;
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    creq_ready  = 1'b0;
    cresp_valid = 1'b0;
    cresp_error = 1'b0;
    cresp_errty = FE_NONE;
    cresp_rdata = '0;
    mreq_valid  = 1'b0;
    mreq_addr   = '0;
    mreq_wen    = 1'b0;
    mreq_wdata  = '0;
    case (state_q)
      IDLE: begin
        creq_ready = 1'b1;
        if (creq_valid) begin
          if (!req_ok)                                      state_d = RESP;
          else if (creq_wen && (creq_wmask == SIZE_W)) state_d = ISSUE_WR;
          else                                              state_d = ISSUE_RD;
        end
      end
      ISSUE_RD: begin
        mreq_valid = 1'b1;
        mreq_addr  = word_addr;
        if (mreq_ready) state_d = WAIT_RD;
      end
      WAIT_RD: begin
        if (resp_hit) state_d = (mresp_error || !wen_q) ? RESP : ISSUE_WR;
      end
      ISSUE_WR: begin
        mreq_valid = 1'b1;
        mreq_addr  = word_addr;
        mreq_wen   = 1'b1;
        mreq_wdata = wdata_q;
        if (mreq_ready) state_d = WAIT_WR;
      end
      WAIT_WR: begin
        if (resp_hit) state_d = RESP;
      end
      RESP: begin
        cresp_valid = 1'b1;
        cresp_error = err_q;
        cresp_errty = err_q ? FE_ACCESS_FAULT : FE_NONE;
        cresp_rdata = rdata_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_membus_bridge.sv
// Randomized bench for cache_membus_bridge: the bench plays both the cache and
// the memory bus, predicting every output from a transaction-level model.
module tb_cache_membus_bridge;
  import cache_membus_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        creq_valid, creq_ready, creq_wen;
  logic [31:0] creq_addr, creq_wdata;
  logic [1:0]  creq_wmask;
  logic        cresp_valid, cresp_error, cresp_errty;
  logic [31:0] cresp_rdata;
  logic        mreq_valid, mreq_ready, mreq_wen;
  logic [31:0] mreq_addr, mreq_wdata;
  logic        mresp_valid, mresp_error;
  logic [31:0] mresp_addr, mresp_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cache_membus_bridge #(.CHECK_RESP_ADDR(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .creq_valid  (creq_valid),
    .creq_ready  (creq_ready),
    .creq_addr   (creq_addr),
    .creq_wen    (creq_wen),
    .creq_wdata  (creq_wdata),
    .creq_wmask  (creq_wmask),
    .cresp_valid (cresp_valid),
    .cresp_error (cresp_error),
    .cresp_errty (cresp_errty),
    .cresp_rdata (cresp_rdata),
    .mreq_valid  (mreq_valid),
    .mreq_ready  (mreq_ready),
    .mreq_addr   (mreq_addr),
    .mreq_wen    (mreq_wen),
    .mreq_wdata  (mreq_wdata),
    .mresp_valid (mresp_valid),
    .mresp_error (mresp_error),
    .mresp_addr  (mresp_addr),
    .mresp_rdata (mresp_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference rules, written in terms of bytes rather than masks and shifts.
  function automatic bit ref_aligned(input logic [1:0] size, input logic [31:0] addr);
    int nbytes;
    if (size == 2'd3) return 1'b0;
    nbytes = 1 << size;
    return (addr % nbytes) == 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int off, input logic [1:0] size);
    logic [31:0] r;
    int nbytes;
    nbytes = 1 << size;
    r = '0;
    for (int i = 0; i < nbytes; i++) r[8*i +: 8] = word[8*(off+i) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nd, input int off, input logic [1:0] size);
    logic [31:0] r;
    int nbytes;
    nbytes = 1 << size;
    r = old;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nbytes) r[8*i +: 8] = nd[8*(i-off) +: 8];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_resp(input logic err, input logic [31:0] rdata);
    check("cresp_valid", {31'd0, cresp_valid}, 32'd1);
    check("cresp_error", {31'd0, cresp_error}, {31'd0, err});
    check("cresp_errty", {31'd0, cresp_errty}, err ? {31'd0, FE_ACCESS_FAULT} : 32'd0);
    check("cresp_rdata", cresp_rdata, rdata);
    check("resp_creq_ready", {31'd0, creq_ready}, 32'd0);
    check("resp_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    tick();
    check("cresp_pulse_end", {31'd0, cresp_valid}, 32'd0);
    check("idle_creq_ready", {31'd0, creq_ready}, 32'd1);
  endtask

  // Holds mreq_ready low for `stall` cycles, optionally driving stray
  // responses, and checks the request stays stable until it is taken.
  task automatic bus_issue(input logic [31:0] ea, input logic ewen, input logic [31:0] ewdata,
                           input int stall, input bit noise);
    for (int i = 0; i <= stall; i++) begin
      check("mreq_valid", {31'd0, mreq_valid}, 32'd1);
      check("mreq_addr", mreq_addr, ea);
      check("mreq_wen", {31'd0, mreq_wen}, {31'd0, ewen});
      if (ewen) check("mreq_wdata", mreq_wdata, ewdata);
      check("issue_cresp_valid", {31'd0, cresp_valid}, 32'd0);
      mresp_valid = noise;
      mresp_addr  = ea;
      mresp_rdata = $urandom;
      mresp_error = 1'b0;
      if (i == stall) mreq_ready = 1'b1;
      @(posedge clk);
      #1;
      mreq_ready  = 1'b0;
      mresp_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic bus_respond(input logic [31:0] ea, input logic err, input logic [31:0] rdata,
                             input int dly, input bit wrong);
    for (int i = 0; i < dly; i++) begin
      check("wait_mreq_valid", {31'd0, mreq_valid}, 32'd0);
      check("wait_cresp_valid", {31'd0, cresp_valid}, 32'd0);
      tick();
    end
    if (wrong) begin
      mresp_valid = 1'b1;
      mresp_addr  = ea + 32'd4;
      mresp_error = $urandom_range(0, 1);
      mresp_rdata = $urandom;
      @(posedge clk);
      #1 mresp_valid = 1'b0;
      @(negedge clk);
      check("wrongaddr_cresp", {31'd0, cresp_valid}, 32'd0);
      check("wrongaddr_mreq", {31'd0, mreq_valid}, 32'd0);
    end
    mresp_valid = 1'b1;
    mresp_addr  = ea;
    mresp_error = err;
    mresp_rdata = rdata;
    @(posedge clk);
    #1;
    mresp_valid = 1'b0;
    mresp_error = 1'b0;
    @(negedge clk);
  endtask

  task automatic accept(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                        input logic [1:0] size);
    check("accept_creq_ready", {31'd0, creq_ready}, 32'd1);
    creq_valid = 1'b1;
    creq_addr  = addr;
    creq_wen   = wen;
    creq_wdata = wdata;
    creq_wmask = size;
    @(posedge clk);
    #1;
    creq_valid = 1'b0;
    creq_addr  = $urandom;
    creq_wdata = $urandom;
    @(negedge clk);
  endtask

  task automatic run_txn(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                         input logic [1:0] size, input logic [31:0] bus_word, input logic rd_err,
                         input logic wr_err, input int stall, input int rdly, input bit wrong,
                         input bit noise);
    logic [31:0] ea;
    int          off;
    ea  = {addr[31:2], 2'b00};
    off = int'(addr[1:0]);
    accept(addr, wen, wdata, size);
    if (!ref_aligned(size, addr)) begin
      check("fault_no_mreq", {31'd0, mreq_valid}, 32'd0);
      expect_resp(1'b1, 32'd0);
    end else if (wen && size == 2'd2) begin
      bus_issue(ea, 1'b1, wdata, stall, noise);
      bus_respond(ea, wr_err, $urandom, rdly, wrong);
      expect_resp(wr_err, 32'd0);
    end else begin
      bus_issue(ea, 1'b0, 32'd0, stall, noise);
      bus_respond(ea, rd_err, bus_word, rdly, wrong);
      if (rd_err) begin
        expect_resp(1'b1, 32'd0);
      end else if (!wen) begin
        expect_resp(1'b0, ref_load(bus_word, off, size));
      end else begin
        bus_issue(ea, 1'b1, ref_merge(bus_word, wdata, off, size), stall, noise);
        bus_respond(ea, wr_err, $urandom, rdly, wrong);
        expect_resp(wr_err, 32'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    creq_valid = 1'b0; creq_addr = '0; creq_wen = 1'b0; creq_wdata = '0; creq_wmask = '0;
    mreq_ready = 1'b0; mresp_valid = 1'b0; mresp_error = 1'b0; mresp_addr = '0; mresp_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_creq_ready", {31'd0, creq_ready}, 32'd1);
    check("rst_cresp_valid", {31'd0, cresp_valid}, 32'd0);
    check("rst_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    check("rst_mreq_addr", mreq_addr, 32'd0);
    check("rst_cresp_rdata", cresp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    run_txn(32'h1000, 1'b0, 32'd0, 2'd2, 32'hDEADBEEF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h1003, 1'b0, 32'd0, 2'd0, 32'hAABBCCDD, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h2002, 1'b1, 32'h00001234, 2'd1, 32'h11223344, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h3001, 1'b1, 32'h55667788, 2'd2, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h3002, 1'b0, 32'd0, 2'd3, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h3005, 1'b0, 32'd0, 2'd1, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h4001, 1'b1, 32'h000000EE, 2'd0, 32'h01020304, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    run_txn(32'h5002, 1'b0, 32'd0, 2'd1, 32'hCAFEF00D, 1'b0, 1'b0, 5, 2, 1'b1, 1'b1);
    run_txn(32'h6000, 1'b1, 32'h0BADC0DE, 2'd2, 32'd0, 1'b0, 1'b1, 2, 1, 1'b1, 1'b0);

    // Reset while waiting for read data, then a stale response in IDLE.
    accept(32'h7000, 1'b0, 32'd0, 2'd2);
    bus_issue(32'h7000, 1'b0, 32'd0, 1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_creq_ready", {31'd0, creq_ready}, 32'd1);
    check("midrst_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    check("midrst_cresp_valid", {31'd0, cresp_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mresp_valid = 1'b1; mresp_addr = 32'h7000; mresp_rdata = 32'h12345678; mresp_error = 1'b0;
    @(posedge clk);
    #1 mresp_valid = 1'b0;
    @(negedge clk);
    check("stale_cresp_valid", {31'd0, cresp_valid}, 32'd0);
    check("stale_creq_ready", {31'd0, creq_ready}, 32'd1);
    check("stale_mreq_valid", {31'd0, mreq_valid}, 32'd0);
    run_txn(32'h7002, 1'b0, 32'd0, 2'd1, 32'h89ABCDEF, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0);

    for (int t = 0; t < 250; t++) begin
      logic [31:0] a;
      a = $urandom;
      run_txn(a, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
